// File: rtl/bcd_seg7_scan_if.sv
// Display-side bundle: packed BCD load strobe in, multiplexed common-anode pins out.
interface bcd_seg7_scan_if;
  logic [11:0] bcd;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  digit_en;
  logic        frame_done;

  modport master (output bcd, load, input seg, dp, digit_en, frame_done);
  modport slave  (input bcd, load, output seg, dp, digit_en, frame_done);
endinterface

// File: rtl/bcd_seg7_scan.sv
// 3-digit multiplexed 7-segment driver: frame-aligned BCD capture, leading-zero
// blanking, dash for non-BCD nibbles, dead time at the start of each digit slot.
module bcd_seg7_scan #(
  parameter int DIV_COUNT = 4000,
  parameter int BLANK_CYC = 200,
  parameter bit LZ_BLANK  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  bcd_seg7_scan_if.slave io
);
  localparam int             CW      = $clog2(DIV_COUNT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV_COUNT - 1);
  localparam logic [CW-1:0]  BLANK_C = CW'(BLANK_CYC);

  generate
    if (DIV_COUNT < 4 || BLANK_CYC < 0 || BLANK_CYC >= DIV_COUNT) begin : g_param_err
      $error("bcd_seg7_scan: need DIV_COUNT >= 4 and 0 <= BLANK_CYC < DIV_COUNT");
    end
  endgenerate

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [11:0]   disp_q, disp_d, pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    digit_en_q, digit_en_d;
  logic          frame_done_q, frame_done_d;

  logic          tick, boundary, blank, lit;
  logic [3:0]    nib;

  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    boundary     = tick && (slot_q == 2'd2);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    slot_d       = slot_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    frame_done_d = boundary;

    if (tick) slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;

    // A load landing on the boundary itself supersedes anything pending.
    if (boundary) begin
      if (io.load) begin
        disp_d   = io.bcd;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (io.load) begin
      pend_d   = io.bcd;
      pend_v_d = 1'b1;
    end

    case (slot_q)
      2'd0:    nib = disp_q[3:0];
      2'd1:    nib = disp_q[7:4];
      default: nib = disp_q[11:8];
    endcase

    // Only a literal zero blanks, so a non-BCD nibble always shows its dash.
    blank = LZ_BLANK && (((slot_q == 2'd2) && (disp_q[11:8] == 4'd0)) ||
                         ((slot_q == 2'd1) && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0)));
    lit   = (cnt_q >= BLANK_C) && !blank;

    seg_d      = lit ? seg7(nib) : 7'h7F;
    digit_en_d = lit ? ~(3'b001 << slot_q) : 3'b111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      disp_q       <= 12'h000;
      pend_q       <= 12'h000;
      pend_v_q     <= 1'b0;
      seg_q        <= 7'h7F;
      digit_en_q   <= 3'b111;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      seg_q        <= seg_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign io.seg        = seg_q;
  assign io.dp         = 1'b1;
  assign io.digit_en   = digit_en_q;
  assign io.frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Scoreboard bench: per-cycle expected pin state from a frame/slot arithmetic model,
// checked on two instances (leading-zero blanking on and off).
module tb_bcd_seg7_scan;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FR  = 3 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_seg7_scan_if ifa ();
  bcd_seg7_scan_if ifb ();
  assign ifb.bcd  = ifa.bcd;
  assign ifb.load = ifa.load;

  bcd_seg7_scan #(.DIV_COUNT(DIV), .BLANK_CYC(BLK), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .io(ifa.slave));
  bcd_seg7_scan #(.DIV_COUNT(DIV), .BLANK_CYC(BLK), .LZ_BLANK(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .io(ifb.slave));

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] den;
    logic       fd;
    logic [6:0] seg_nz;
    logic [2:0] den_nz;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_t;
  logic [11:0] m_disp, m_pend;
  bit          m_pv;

  function automatic logic [6:0] pat(input logic [3:0] d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d <= 4'd9) ? tbl[d] : 7'h3F;
  endfunction

  // What the panel shows t cycles into the run for displayed value v.
  function automatic logic [9:0] view(input int t, input logic [11:0] v, input bit lz);
    int         cnt  = t % DIV;
    int         slot = (t / DIV) % 3;
    logic [3:0] d    = v[slot*4 +: 4];
    bit         blank;
    blank = lz && ((slot == 2 && v[11:8] == 0) || (slot == 1 && v[11:8] == 0 && v[7:4] == 0));
    if (cnt < BLK || blank) return {7'h7F, 3'b111};
    return {pat(d), 3'(~(1 << slot))};
  endfunction

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int i = 0; i < 3; i++)
      v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit l, input logic [11:0] b);
    exp_t e;
    bit   boundary;
    @(negedge clk);
    if (rst_n && !r) begin
      rst_n = 1'b0;
      #1;
      check("async_rst", {ifa.seg, ifa.digit_en, ifa.frame_done, ifa.dp, ifb.seg, ifb.digit_en},
            {7'h7F, 3'b111, 1'b0, 1'b1, 7'h7F, 3'b111});
      q.delete();
    end
    rst_n    = r;
    ifa.load = l;
    ifa.bcd  = b;
    if (!r) begin
      m_t = 0; m_disp = '0; m_pend = '0; m_pv = 0;
      e = {7'h7F, 3'b111, 1'b0, 7'h7F, 3'b111};
      q.push_back(e);
    end else begin
      boundary = (m_t % FR) == FR - 1;
      e = {view(m_t, m_disp, 1'b1), boundary, view(m_t, m_disp, 1'b0)};
      q.push_back(e);
      if (boundary) begin
        if (l) begin m_disp = b; m_pv = 0; end
        else if (m_pv) begin m_disp = m_pend; m_pv = 0; end
      end else if (l) begin
        m_pend = b; m_pv = 1;
      end
      m_t++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b1, 1'b0, 12'($urandom));
  endtask

  task automatic run_to(input int ph);
    for (int g = 0; g < FR && (m_t % FR) != ph; g++) cyc(1'b1, 1'b0, 12'($urandom));
    check("run_to_phase", 32'(m_t % FR), 32'(ph));
  endtask

  // Monitor: registered outputs settle just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb", {ifa.seg, ifa.digit_en, ifa.frame_done, ifb.seg, ifb.digit_en, ifb.frame_done, ifa.dp, ifb.dp},
              {e.seg, e.den, e.fd, e.seg_nz, e.den_nz, e.fd, 2'b11});
        check("en_onehot", 32'($countones(~ifa.digit_en) <= 1 && $countones(~ifb.digit_en) <= 1), 32'd1);
        check("dark_seg", {(ifa.digit_en == 3'b111) ? ifa.seg : 7'h7F, (ifb.digit_en == 3'b111) ? ifb.seg : 7'h7F},
              {7'h7F, 7'h7F});
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    ifa.load = 1'b0;
    ifa.bcd  = 12'h000;
    m_t = 0; m_disp = '0; m_pend = '0; m_pv = 0;
    #1 rst_n = 1'b0;
    #1 check("reset", {ifa.seg, ifa.digit_en, ifa.frame_done, ifa.dp}, {7'h7F, 3'b111, 1'b0, 1'b1});
    cyc(1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 12'h000);
    cyc(1'b1, 1'b0, 12'h000);
    run(3 * FR - 1);

    run_to(10); cyc(1'b1, 1'b1, 12'h305); run(2 * FR);

    run_to(3);  cyc(1'b1, 1'b1, 12'h007);
    run_to(15); cyc(1'b1, 1'b1, 12'h042); run(2 * FR);

    run_to(5);  cyc(1'b1, 1'b1, 12'h111);
    run_to(23); cyc(1'b1, 1'b1, 12'h999); run(2 * FR);

    run_to(2);  cyc(1'b1, 1'b1, 12'h0A0); run(2 * FR);

    // Pending value then async reset at slot 1, cnt 5.
    run_to(4);  cyc(1'b1, 1'b1, 12'h456);
    run_to(13); cyc(1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 12'h000);
    cyc(1'b1, 1'b0, 12'h000);
    run(3 * FR);

    repeat (10 * FR) cyc(1'b1, ($urandom_range(0, 5) == 0), rand_bcd());
    run(2);
    @(posedge clk);
    #3;
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_seg7_scan.md
Name: bcd_seg7_scan

Overview:
- Takes the 12-bit packed BCD (3 digits) produced by the binary-to-BCD stage and drives a multiplexed 3-digit common-anode seven-segment display.
- Samples input only at frame boundaries, so displayed values never tear mid-scan.
- Provides leading-zero blanking, invalid-digit indication, and anti-ghosting dead time.
- Sits directly downstream of the binary-to-BCD converter and feeds the board display pins.

Parameters:
- DIV_COUNT, 4000: clocks per digit slot (12 MHz / 4000 = 3 kHz slot rate, 1 kHz frame); legal range ≥ 4.
- BLANK_CYC, 200: dead-time clocks at the start of each slot with all digits off; must be < DIV_COUNT.
- LZ_BLANK, 1: 1 enables leading-zero blanking, 0 shows all three digits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- bcd  input  12  {hundreds[11:8], tens[7:4], units[3:0]}.
- load  input  1  one-cycle strobe; capture bcd as the pending value.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).
- digit_en  output  3  [0]=units, [1]=tens, [2]=hundreds, active-low.
- frame_done  output  1  one-cycle pulse at the end of each 3-slot frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); all state is cleared on assertion and released on the next clk edge after deassertion.
- Reset values:
  - Prescaler cnt=0, slot=0, disp=12'h000, pend=0, pend_v=0.
  - seg=7'h7F, dp=1, digit_en=3'b111, frame_done=0.
- Prescaler:
  - cnt counts 0..DIV_COUNT-1 and wraps.
  - tick is high when cnt==DIV_COUNT-1.
  - On tick, slot advances 0→1→2→0 (units, tens, hundreds).
- Frame boundary (tick with slot==2):
  - frame_done pulses on the next cycle.
  - If load is high in the boundary cycle, bcd is written directly to disp (bypass) and pend_v is cleared.
  - Otherwise, if pend_v=1, pend is written to disp and pend_v is cleared.
  - Otherwise disp holds.
- Load outside a boundary cycle: pend<=bcd, pend_v<=1. When several loads occur in one frame, the last one wins.
- Digit enable:
  - The slot's digit is enabled only while cnt ≥ BLANK_CYC and the digit is not blanked.
  - At most one digit_en bit is low at any time.
- Leading-zero blanking (LZ_BLANK=1):
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds==0 and tens==0.
  - Units is never blanked.
  - A blanked digit keeps digit_en high and seg=7'h7F.
- Decode (active-low seg, standard patterns):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Nibbles A–F show a dash, 7'h3F (segment g only).
  - An invalid nibble is never blanked by the leading-zero rule.
- Output timing:
  - seg and digit_en are registered and reflect cnt/slot/disp of the previous clock (1-cycle latency).
  - During dead time, seg=7'h7F.
- Reset mid-frame: outputs go immediately to reset values. The pending load is discarded, and the display restarts at slot 0 showing "0" on units.
- Parameter legality (DIV_COUNT ≥ 4, BLANK_CYC < DIV_COUNT) is checked at elaboration with a simulation-only error.

Test Plan (use DIV_COUNT=8, BLANK_CYC=2):
- Reset, then run 3 frames with no load:
  - digit_en[0] is low for 6 of every 24 clocks, digit_en[2:1] stay high, seg=7'h40 while enabled.
  - frame_done pulses every 24 clocks.
- Load bcd=12'h305 mid-frame:
  - The current frame still shows the old value.
  - From the next frame: units seg=7'h12, tens seg=7'h40 (not blanked, since hundreds≠0), hundreds seg=7'h30.
- Load 12'h007, then 12'h042, within one frame:
  - After the boundary only 042 is shown: hundreds blanked, tens=7'h19, units=7'h24.
  - With LZ_BLANK=0, hundreds shows 7'h40.
- Assert load with 12'h999 exactly on a boundary cycle while 12'h111 is pending:
  - 999 is shown next frame, 111 is never displayed, and pend_v is 0 afterwards.
- Load 12'h0A0:
  - Tens shows 7'h3F, hundreds is blanked, units=7'h40.
- Assert rst_n=0 at slot 1, cnt=5, with a pending load:
  - Outputs are at reset values within the same cycle (asynchronous).
  - After release, units shows "0" and the pending value is never displayed.
- Run a 10-frame random load soak:
  - Assertion: digit_en is never low in more than one bit.
  - Assertion: seg=7'h7F whenever digit_en==3'b111.
